// File: rtl/evt_rr_arbiter.sv
// ============================================================================
//  Module      : evt_rr_arbiter
//  Description : Round-robin merge of N_INP event streams into one registered
//                output, with a per-grant burst limit and per-input enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module evt_rr_arbiter #(
    parameter int N_INP     = 2,
    parameter int EVT_WIDTH = 32,
    parameter int MAX_BURST = 4,
    parameter int SRC_W     = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [N_INP-1:0]                    en_i,
    input  logic [N_INP-1:0]                    inp_valid_i,
    output logic [N_INP-1:0]                    inp_ready_o,
    input  logic [N_INP-1:0][EVT_WIDTH-1:0]     inp_evt_i,
    output logic                                oup_valid_o,
    input  logic                                oup_ready_i,
    output logic [EVT_WIDTH-1:0]                oup_evt_o,
    output logic [SRC_W-1:0]                    oup_src_o,
    output logic                                busy_o
);

    localparam logic [0:0]   c_st_arb    = 1'b0;
    localparam logic [0:0]   c_st_hold   = 1'b1;
    localparam logic [7:0]   c_max_burst = 8'(MAX_BURST);
    localparam logic [SRC_W:0] c_n       = (SRC_W+1)'(N_INP);

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [SRC_W-1:0]       r_cur;
    logic [SRC_W-1:0]       r_ptr;
    logic [7:0]             r_burst;
    logic                   r_valid;
    logic [EVT_WIDTH-1:0]   r_evt;
    logic [SRC_W-1:0]       r_src;

    logic                   w_load_en;
    logic [N_INP-1:0]       w_cand;
    logic [N_INP-1:0]       w_cand_sh;
    logic                   w_cur_cand;
    logic [2*N_INP-1:0]     w_rot2;
    logic [N_INP-1:0]       w_rot;
    logic [SRC_W:0]         w_off;
    logic [SRC_W:0]         w_sum;
    logic                   w_rr_vld;
    logic [SRC_W-1:0]       w_sel;
    logic                   w_sel_vld;
    logic                   w_xfer;
    logic                   w_cont;
    logic [7:0]             w_burst_nxt;
    logic [SRC_W:0]         w_ptr_nxt;

    assign w_load_en  = !r_valid || oup_ready_i;
    assign w_cand     = inp_valid_i & en_i;
    assign w_cand_sh  = w_cand >> r_cur;
    assign w_cur_cand = w_cand_sh[0];

    // Rotate the candidate vector so bit 0 is the pointer position; the
    // lowest set bit of the rotated vector is the round-robin winner.
    always_comb begin
        w_rot2   = {w_cand, w_cand} >> r_ptr;
        w_rot    = w_rot2[N_INP-1:0];
        w_off    = '0;
        w_rr_vld = 1'b0;
        for (int k = N_INP - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off    = (SRC_W+1)'(k);
                w_rr_vld = 1'b1;
            end
        end
        w_sum = {1'b0, r_ptr} + w_off;
        if (w_sum >= c_n) begin
            w_sum = w_sum - c_n;
        end
    end

    always_comb begin
        w_sel     = w_sum[SRC_W-1:0];
        w_sel_vld = w_rr_vld;
        if (r_state == c_st_hold && w_cur_cand && r_burst < c_max_burst) begin
            w_sel     = r_cur;
            w_sel_vld = 1'b1;
        end
    end

    assign w_xfer      = w_load_en && w_sel_vld;
    assign w_cont      = (r_state == c_st_hold) && (w_sel == r_cur);
    assign w_burst_nxt = w_cont ? (r_burst + 8'd1) : 8'd1;

    always_comb begin
        w_ptr_nxt = {1'b0, w_sel} + (SRC_W+1)'(1);
        if (w_ptr_nxt >= c_n) begin
            w_ptr_nxt = '0;
        end
    end

    // Next state: a transfer (re)enters HOLD unless it exhausts the burst;
    // an idle or disabled owner releases the grant.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = (w_burst_nxt == c_max_burst) ? c_st_arb : c_st_hold;
        end else if (w_load_en && !w_cur_cand) begin
            w_state_nxt = c_st_arb;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_st_arb;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cur   <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
            r_valid <= 1'b0;
            r_evt   <= '0;
            r_src   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_evt   <= inp_evt_i[w_sel];
            r_src   <= w_sel;
            r_burst <= w_burst_nxt;
            if (!w_cont) begin
                r_cur <= w_sel;
                r_ptr <= w_ptr_nxt[SRC_W-1:0];
            end
        end else if (w_load_en) begin
            r_valid <= 1'b0;
        end
    end

    // Ready is gated by reset so no handshake can be seen while it is held.
    assign inp_ready_o = (w_xfer && !rst_i) ? ((N_INP)'(1) << w_sel) : '0;
    assign oup_valid_o = r_valid;
    assign oup_evt_o   = r_evt;
    assign oup_src_o   = r_src;
    assign busy_o      = r_valid || (r_state == c_st_hold);

endmodule

`default_nettype wire

// File: tb/tb_evt_rr_arbiter.sv
// ============================================================================
//  Module      : tb_evt_rr_arbiter
//  Description : Directed and random stimulus for evt_rr_arbiter with a
//                rule-level reference model and per-source scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_evt_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N-1:0]          en = '0;
    logic [N-1:0]          valid = '0;
    logic [N-1:0]          ready;
    logic [N-1:0][W-1:0]   evt;
    logic                  oup_valid;
    logic                  oup_ready = 1'b0;
    logic [W-1:0]          oup_evt;
    logic [1:0]            oup_src;
    logic                  busy;

    evt_rr_arbiter #(.N_INP(N), .EVT_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .inp_valid_i (valid),
        .inp_ready_o (ready),
        .inp_evt_i   (evt),
        .oup_valid_o (oup_valid),
        .oup_ready_i (oup_ready),
        .oup_evt_o   (oup_evt),
        .oup_src_o   (oup_src),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stream contents: each input emits {source, sequence number}.
    int seq [N];
    int out_seq [N];

    // Reference model state, expressed as the arbitration rules.
    bit          m_hold;
    int          m_cur, m_cnt, m_ptr;
    bit          m_valid;
    logic [W-1:0] m_evt;
    int          m_src;

    logic [N-1:0] obs_ready;
    logic         obs_valid;
    logic [1:0]   obs_src;
    logic [W-1:0] obs_evt;

    function automatic logic [W-1:0] mkevt(int i);
        return {8'(i), 24'(seq[i])};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
        m_valid = 0; m_evt = '0; m_src = 0;
        for (int i = 0; i < N; i++) out_seq[i] = seq[i];
    endtask

    task automatic load_evts();
        for (int i = 0; i < N; i++) evt[i] = mkevt(i);
    endtask

    // One cycle: compare at the falling edge, advance model, cross rising edge.
    task automatic step();
        bit [N-1:0] cand, exp_rdy;
        bit load, selv;
        int sel, idx;
        @(negedge clk);
        obs_ready = ready; obs_valid = oup_valid; obs_src = oup_src; obs_evt = oup_evt;
        cand = valid & en;
        load = !m_valid || oup_ready;
        selv = 0; sel = 0;
        if (m_hold && cand[m_cur] && m_cnt < MB) begin
            selv = 1; sel = m_cur;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!selv && cand[idx]) begin selv = 1; sel = idx; end
            end
        end
        exp_rdy = (load && selv) ? (N'(1) << sel) : '0;
        chk("ready", 64'(ready), 64'(exp_rdy));
        chk("oup_valid", 64'(oup_valid), 64'(m_valid));
        chk("oup_evt", 64'(oup_evt), 64'(m_evt));
        chk("oup_src", 64'(oup_src), 64'(m_src));
        chk("busy", 64'(busy), 64'(m_valid || m_hold));
        if (oup_valid && oup_ready) begin
            chk("drain_seq", 64'(oup_evt), 64'({8'(oup_src), 24'(out_seq[oup_src])}));
            out_seq[oup_src]++;
        end
        if (load && selv) begin
            m_evt = evt[sel]; m_src = sel; m_valid = 1;
            if (m_hold && sel == m_cur) begin
                m_cnt++;
            end else begin
                m_cur = sel; m_cnt = 1; m_ptr = (sel + 1) % N; m_hold = 1;
            end
            if (m_cnt == MB) m_hold = 0;
            seq[sel]++;
        end else if (load) begin
            m_valid = 0;
            if (m_hold && !cand[m_cur]) m_hold = 0;
        end
        @(posedge clk); #1;
        load_evts();
    endtask

    // Reset with random inputs; outputs must clear without waiting for a clock.
    task automatic do_reset();
        valid = N'($urandom); en = N'($urandom); oup_ready = 1'($urandom);
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(oup_valid), 0);
        chk("rst_evt", 64'(oup_evt), 0);
        chk("rst_src", 64'(oup_src), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(ready), 0);
        @(negedge clk);
        chk("rst_ready_hold", 64'(ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        load_evts();
    endtask

    initial begin
        int found;
        logic [W-1:0] held;
        for (int i = 0; i < N; i++) begin seq[i] = 0; out_seq[i] = 0; end
        load_evts();
        @(posedge clk); #1;
        do_reset();

        // Full load, burst of two per input in rotating order.
        en = '1; valid = '1; oup_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k >= 1) begin
                chk("rr_valid", 64'(obs_valid), 1);
                chk("rr_src", 64'(obs_src), 64'(((k - 1) >> 1) & 3));
            end
        end

        // Backpressure holds the output and blocks every input.
        oup_ready = 1'b0;
        held = m_evt;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_ready", 64'(obs_ready), 0);
            chk("bp_evt", 64'(obs_evt), 64'(held));
        end
        oup_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // Single active source streams without bubbles across bursts.
        valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k >= 2) begin
                chk("single_src", 64'(obs_src), 2);
                chk("single_valid", 64'(obs_valid), 1);
            end
        end

        // Masked input is never served; once enabled it wins within 3 bursts.
        en = 4'b1011; valid = '1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("mask_ready2", 64'(obs_ready[2]), 0);
            if (k >= 1) chk("mask_src_not2", 64'(obs_src == 2'd2), 0);
        end
        en = '1;
        found = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (found < 0 && k >= 1 && obs_src == 2'd2) found = k;
        end
        chk("mask_regrant", 64'(found >= 1 && found <= 3 * MB), 1);

        // Owner going idle mid-burst hands over from the pointer, not index 0.
        do_reset();
        en = '1; oup_ready = 1'b1; valid = 4'b0010;
        step();
        chk("idle_first", 64'(obs_ready), 64'(4'b0010));
        valid = 4'b1101;
        step();
        chk("idle_next", 64'(obs_ready), 64'(4'b0100));

        // Random traffic, enables and backpressure.
        for (int k = 0; k < 400; k++) begin
            valid     = N'($urandom);
            en        = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            oup_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Reset in the middle of traffic discards the pending event.
        valid = '1; en = '1; oup_ready = 1'b0;
        step();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            valid     = N'($urandom);
            en        = '1;
            oup_ready = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
